laplace_window_filter: RTL and testbench
========================================

Name: laplace_window_filter

Overview:
- Streaming 3x3 Laplacian edge filter.
- Each transfer delivers one image column of three vertically adjacent pixels (top, middle, bottom rows). The block keeps a 3-column sliding window and emits one 8-bit edge magnitude per accepted column.
- It sits between the three row line buffers and the output packing FIFO of the Laplace pipeline. The downstream thresholding (>=16 -> 0xFF) is done outside this block.

Parameters:
- PIXEL_W, 8, bits per pixel, in and out.
- LINE_WIDTH, 512, columns per image line; sets the column counter wrap point.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset, synchronous, active-low.
- i_pixel_1  in  PIXEL_W  top-row pixel of the current column.
- i_pixel_2  in  PIXEL_W  middle-row pixel of the current column.
- i_pixel_3  in  PIXEL_W  bottom-row pixel of the current column.
- i_pixel_valid  in  1  input column valid.
- o_pixel_ack  out  1  ready; a column is accepted when i_pixel_valid && o_pixel_ack.
- o_pixel_valid  out  1  o_pixel holds a result.
- i_pixel_ack  in  1  downstream ready (FIFO not full); a result is consumed when o_pixel_valid && i_pixel_ack.
- o_pixel  out  PIXEL_W  edge magnitude.

Behaviour:
- Reset, checked at a clock edge with i_rst=0:
  - o_pixel_valid=0, o_pixel=0.
  - All 9 window registers = 0; column counter = 0.
  - Reset mid-line discards any partial window and any pending output.
- Ready: o_pixel_ack = !o_pixel_valid || i_pixel_ack (combinational). This is a one-deep output register with pass-through on drain.
- On accept:
  - Window shifts left: col0<=col1, col1<=col2, col2<=new column.
  - Column counter k increments; it wraps LINE_WIDTH-1 -> 0.
  - The result is registered into o_pixel, and o_pixel_valid=1 on the next cycle. Latency is 1 cycle from accept to valid.
- Output value for accepted column index k:
  - k=0 or k=1: 0 (left border).
  - k>=2: window centred on column k-1, computed with the shifted window including the new column.
  - The centre of column LINE_WIDTH-1 is never produced.
  - Outputs per line = LINE_WIDTH exactly, so downstream 8-byte packing stays aligned.
- Kernel, 8-neighbour: L = 8*C - (sum of the 8 neighbours).
  - Use at least 12-bit signed arithmetic; the range is -2040..+2040.
  - o_pixel = min(|L|, 255).
- Backpressure:
  - While o_pixel_valid=1 and i_pixel_ack=0, hold o_pixel, o_pixel_valid, the window and the counter; o_pixel_ack=0.
  - Accept and consume in the same cycle is allowed: the new result replaces the old one, and valid stays 1.
  - If there is no accept in a cycle where the result is consumed, o_pixel_valid<=0.
- i_pixel_valid gaps (inter-line idle) do not alter the window or the counter.
- Inputs are sampled only on an accept; values while not accepted are ignored.

Decomposition:
- Package laplace_pkg:
  - PIXEL_W and LINE_WIDTH defaults.
  - Accumulator width constant (12).
  - Kernel centre weight constant (8).
  - Saturation max (255).
- One sub-module, laplace_kernel: combinational 3x3 -> saturated |L|.
- The top level holds the window, the counter and the handshake.

Test Plan:
- Flat image: every pixel 100, one line of 512 columns, i_pixel_ack=1 -> 512 outputs, all 0. The first o_pixel_valid occurs 1 cycle after the first accept.
- Single bright dot:
  - Setup: middle row, column 10 = 200; all other pixels 0.
  - Outputs 0..9 and 13..511 = 0.
  - Output 11 (centre col 10): 8*200 = 1600 -> saturated 255.
  - Outputs 10 and 12 (neighbour centres): |-200| = 200.
- Small gradient:
  - Setup: centre 20, neighbours 18.
  - L = 160 - 144 = 16 -> o_pixel = 16 at the matching index.
  - Negative case: centre 10, neighbours 12 -> L = -16 -> o_pixel = 16.
- Backpressure:
  - Hold i_pixel_ack=0 for 5 cycles with a valid result pending -> o_pixel stable, o_pixel_ack=0, no columns consumed.
  - Release -> the stream resumes with no loss or duplication; the output sequence equals the no-stall run.
- Line wrap: stream 2 lines back-to-back with an idle gap -> outputs 0 and 1 of line 2 = 0 regardless of line 1 data. Total outputs = 1024.
- Reset mid-line: assert i_rst=0 after 100 columns -> o_pixel_valid=0 next cycle. A new line afterwards starts with border zeros at k=0 and 1.

Source files
------------

// File: rtl/laplace_pkg.sv
// Shared constants for the streaming 3x3 Laplacian edge filter.
package laplace_pkg;

  localparam int PIXEL_W_DEF    = 8;
  localparam int LINE_WIDTH_DEF = 512;
  // 8*255 = 2040 needs 12 bits signed to hold +/-2040
  localparam int ACC_W          = 12;
  localparam int CENTRE_WEIGHT  = 8;
  localparam int SAT_MAX        = 255;

endpackage

// File: rtl/laplace_kernel.sv
// Combinational 8-neighbour Laplacian: |8*C - sum(neighbours)| saturated to the pixel range.
module laplace_kernel
  import laplace_pkg::*;
#(
  parameter int PIXEL_W = PIXEL_W_DEF
) (
  input  logic [PIXEL_W-1:0] i_p00,
  input  logic [PIXEL_W-1:0] i_p01,
  input  logic [PIXEL_W-1:0] i_p02,
  input  logic [PIXEL_W-1:0] i_p10,
  input  logic [PIXEL_W-1:0] i_p11,
  input  logic [PIXEL_W-1:0] i_p12,
  input  logic [PIXEL_W-1:0] i_p20,
  input  logic [PIXEL_W-1:0] i_p21,
  input  logic [PIXEL_W-1:0] i_p22,
  output logic [PIXEL_W-1:0] o_mag
);

  // Wider pixels need 4 extra bits over the pixel width for the 8x centre term plus sign
  localparam int AW = (PIXEL_W + 4 > ACC_W) ? PIXEL_W + 4 : ACC_W;
  localparam logic [AW-1:0] W_SAT = (PIXEL_W == PIXEL_W_DEF) ? AW'(SAT_MAX)
                                                              : AW'((2 ** PIXEL_W) - 1);

  logic [AW-1:0] w_centre;
  logic [AW-1:0] w_neigh;
  logic [AW-1:0] w_lap;
  logic [AW-1:0] w_abs;

  assign w_centre = AW'(i_p11) * AW'(CENTRE_WEIGHT);
  assign w_neigh  = AW'(i_p00) + AW'(i_p01) + AW'(i_p02)
                  + AW'(i_p10)              + AW'(i_p12)
                  + AW'(i_p20) + AW'(i_p21) + AW'(i_p22);

  // Two's-complement difference; the top bit is the sign
  assign w_lap = w_centre - w_neigh;
  assign w_abs = w_lap[AW-1] ? (~w_lap + AW'(1)) : w_lap;
  assign o_mag = (w_abs > W_SAT) ? W_SAT[PIXEL_W-1:0] : w_abs[PIXEL_W-1:0];

endmodule

// File: rtl/laplace_window_filter.sv
// Streaming 3x3 Laplacian: 3-column sliding window, column counter and a one-deep
// output register with pass-through on drain.
module laplace_window_filter
  import laplace_pkg::*;
#(
  parameter int PIXEL_W    = PIXEL_W_DEF,
  parameter int LINE_WIDTH = LINE_WIDTH_DEF
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [PIXEL_W-1:0] i_pixel_1,
  input  logic [PIXEL_W-1:0] i_pixel_2,
  input  logic [PIXEL_W-1:0] i_pixel_3,
  input  logic               i_pixel_valid,
  output logic               o_pixel_ack,
  output logic               o_pixel_valid,
  input  logic               i_pixel_ack,
  output logic [PIXEL_W-1:0] o_pixel
);

  localparam int CNT_W = (LINE_WIDTH > 2) ? $clog2(LINE_WIDTH) : 2;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LINE_WIDTH - 1);

  // Each column is packed [0]=top, [1]=middle, [2]=bottom
  logic [2:0][PIXEL_W-1:0] r_col0;
  logic [2:0][PIXEL_W-1:0] r_col1;
  logic [2:0][PIXEL_W-1:0] r_col2;
  logic [CNT_W-1:0]        r_col_cnt;
  logic                    r_valid;
  logic [PIXEL_W-1:0]      r_pixel;

  logic                    w_accept;
  logic [2:0][PIXEL_W-1:0] w_new;
  logic [2:0][PIXEL_W-1:0] w_nxt0;
  logic [2:0][PIXEL_W-1:0] w_nxt1;
  logic [2:0][PIXEL_W-1:0] w_nxt2;
  logic [PIXEL_W-1:0]      w_kernel;
  logic                    w_border;

  assign o_pixel_ack   = !r_valid || i_pixel_ack;
  assign o_pixel_valid = r_valid;
  assign o_pixel       = r_pixel;

  assign w_accept = i_pixel_valid && o_pixel_ack;
  assign w_new    = {i_pixel_3, i_pixel_2, i_pixel_1};

  // Next-state window feeds both the registers and the kernel, so the result
  // already includes the column being accepted.
  assign w_nxt0 = w_accept ? r_col1 : r_col0;
  assign w_nxt1 = w_accept ? r_col2 : r_col1;
  assign w_nxt2 = w_accept ? w_new  : r_col2;

  assign w_border = (r_col_cnt < CNT_W'(2));

  laplace_kernel #(
    .PIXEL_W (PIXEL_W)
  ) u_kernel (
    .i_p00 (w_nxt0[0]),
    .i_p01 (w_nxt1[0]),
    .i_p02 (w_nxt2[0]),
    .i_p10 (w_nxt0[1]),
    .i_p11 (w_nxt1[1]),
    .i_p12 (w_nxt2[1]),
    .i_p20 (w_nxt0[2]),
    .i_p21 (w_nxt1[2]),
    .i_p22 (w_nxt2[2]),
    .o_mag (w_kernel)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_col0    <= '0;
      r_col1    <= '0;
      r_col2    <= '0;
      r_col_cnt <= '0;
      r_valid   <= 1'b0;
      r_pixel   <= '0;
    end else begin
      r_col0 <= w_nxt0;
      r_col1 <= w_nxt1;
      r_col2 <= w_nxt2;
      if (w_accept) begin
        r_col_cnt <= (r_col_cnt == CNT_LAST) ? '0 : r_col_cnt + CNT_W'(1);
        r_pixel   <= w_border ? '0 : w_kernel;
        r_valid   <= 1'b1;
      end else if (i_pixel_ack) begin
        r_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_laplace_window_filter.sv
// Scoreboard bench for laplace_window_filter: expected magnitudes pushed on accept, popped on consume.
module tb_laplace_window_filter;

  localparam int PW = 8;
  localparam int LW = 512;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b0;
  logic [PW-1:0] i_pixel_1 = '0;
  logic [PW-1:0] i_pixel_2 = '0;
  logic [PW-1:0] i_pixel_3 = '0;
  logic          i_pixel_valid = 1'b0;
  logic          i_pixel_ack = 1'b1;
  logic          o_pixel_ack;
  logic          o_pixel_valid;
  logic [PW-1:0] o_pixel;

  laplace_window_filter #(
    .PIXEL_W    (PW),
    .LINE_WIDTH (LW)
  ) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_pixel_1     (i_pixel_1),
    .i_pixel_2     (i_pixel_2),
    .i_pixel_3     (i_pixel_3),
    .i_pixel_valid (i_pixel_valid),
    .o_pixel_ack   (o_pixel_ack),
    .o_pixel_valid (o_pixel_valid),
    .i_pixel_ack   (i_pixel_ack),
    .o_pixel       (o_pixel)
  );

  always #5 i_clk = ~i_clk;

  int total = 0;
  int bad   = 0;
  int img[3][LW];
  int exp_q[$];
  int n_out = 0;
  int n_acc = 0;
  bit in_reset = 1'b1;
  string cur_tag = "reset";

  task automatic chk(input string tag, input int got, input int want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0d want=%0d (t=%0t)", tag, got, want, $time);
    end
  endtask

  // Reference magnitude for accepted column c of the line held in img
  function automatic int lap_ref(input int c);
    int s, l;
    if (c < 2) return 0;
    s = 0;
    for (int r = 0; r < 3; r++)
      for (int cc = c - 2; cc <= c; cc++)
        if (!(r == 1 && cc == c - 1)) s += img[r][cc];
    l = 8 * img[1][c-1] - s;
    if (l < 0) l = -l;
    return (l > 255) ? 255 : l;
  endfunction

  task automatic fill(input int v);
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < LW; c++) img[r][c] = v;
  endtask

  task automatic fill_rand();
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < LW; c++) img[r][c] = int'($urandom_range(0, 255));
  endtask

  // Present column c and hold it until accepted; called at posedge+1
  task automatic send_col(input int c);
    int t;
    i_pixel_1 = PW'(img[0][c]);
    i_pixel_2 = PW'(img[1][c]);
    i_pixel_3 = PW'(img[2][c]);
    i_pixel_valid = 1'b1;
    t = 0;
    @(negedge i_clk);
    while (!o_pixel_ack && t < 1000) begin
      @(negedge i_clk);
      t++;
    end
    if (!o_pixel_ack) chk("accept_timeout", 0, 1);
    else begin
      exp_q.push_back(lap_ref(c));
      n_acc++;
    end
    @(posedge i_clk);
    #1;
    i_pixel_valid = 1'b0;
    i_pixel_1 = PW'($urandom_range(0, 255));
    i_pixel_2 = PW'($urandom_range(0, 255));
    i_pixel_3 = PW'($urandom_range(0, 255));
  endtask

  task automatic send_line();
    for (int c = 0; c < LW; c++) send_col(c);
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 2000) begin
      @(negedge i_clk);
      t++;
    end
    chk("drain_left", exp_q.size(), 0);
    @(posedge i_clk);
    #1;
  endtask

  always @(negedge i_clk) begin
    if (!in_reset && o_pixel_valid && i_pixel_ack) begin
      if (exp_q.size() == 0) chk({cur_tag, "_spurious"}, 1, 0);
      else chk({cur_tag, "_pix"}, int'(o_pixel), exp_q.pop_front());
      n_out++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int held, acc0;

    // Reset state
    repeat (3) @(posedge i_clk);
    #1;
    chk("rst_valid", int'(o_pixel_valid), 0);
    chk("rst_pixel", int'(o_pixel), 0);
    chk("rst_ack", int'(o_pixel_ack), 1);
    i_rst = 1'b1;
    in_reset = 1'b0;
    @(posedge i_clk);
    #1;

    // Flat image, also checks 1-cycle latency of the first result
    cur_tag = "flat";
    n_out = 0;
    fill(100);
    chk("flat_pre_valid", int'(o_pixel_valid), 0);
    send_col(0);
    chk("first_latency", int'(o_pixel_valid), 1);
    for (int c = 1; c < LW; c++) send_col(c);
    wait_drain();
    chk("flat_count", n_out, LW);

    // Single bright dot at middle row, column 10
    cur_tag = "dot";
    fill(0);
    img[1][10] = 200;
    send_line();
    wait_drain();

    // Small gradients: +16 centred on column 21, -16 centred on column 40
    cur_tag = "grad";
    fill(0);
    for (int r = 0; r < 3; r++)
      for (int c = 20; c <= 22; c++) img[r][c] = 18;
    img[1][21] = 20;
    for (int r = 0; r < 3; r++)
      for (int c = 39; c <= 41; c++) img[r][c] = 12;
    img[1][40] = 10;
    send_line();
    wait_drain();

    // Backpressure: stall downstream for 5 cycles mid-line
    cur_tag = "bp";
    fill_rand();
    fork
      send_line();
      begin
        repeat (60) @(posedge i_clk);
        #1;
        chk("bp_pending", int'(o_pixel_valid), 1);
        held = int'(o_pixel);
        acc0 = n_acc;
        i_pixel_ack = 1'b0;
        repeat (5) begin
          @(negedge i_clk);
          chk("bp_hold", int'(o_pixel), held);
          chk("bp_ack", int'(o_pixel_ack), 0);
          chk("bp_valid", int'(o_pixel_valid), 1);
          chk("bp_noacc", n_acc, acc0);
        end
        @(posedge i_clk);
        #1;
        i_pixel_ack = 1'b1;
      end
    join
    wait_drain();

    // Two lines with an idle gap; second line borders must ignore line 1
    cur_tag = "wrap";
    n_out = 0;
    fill(255);
    send_line();
    repeat (4) @(posedge i_clk);
    #1;
    fill_rand();
    send_line();
    wait_drain();
    chk("wrap_count", n_out, 2 * LW);

    // Reset mid-line after 100 columns
    cur_tag = "midrst";
    fill_rand();
    for (int c = 0; c < 100; c++) send_col(c);
    in_reset = 1'b1;
    i_rst = 1'b0;
    @(posedge i_clk);
    #1;
    chk("midrst_valid", int'(o_pixel_valid), 0);
    chk("midrst_pixel", int'(o_pixel), 0);
    exp_q.delete();
    i_rst = 1'b1;
    in_reset = 1'b0;
    n_out = 0;
    cur_tag = "after_rst";
    fill_rand();
    send_line();
    wait_drain();
    chk("after_rst_count", n_out, LW);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
